// File: rtl/fetch_stage_component_pkg.sv
// fetch_stage_component_pkg
//   Definitions shared by the fetch stage, the hazard detection unit and the
//   other pipeline stages: instruction/address widths, the bubble
//   instruction default, the fetch FSM state encoding, and small PC helper
//   functions.
package fetch_stage_component_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned ADDR_W = 16;

  // Instruction word used as a pipeline bubble unless a stage overrides it.
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 16'h0000;

  // Fetch FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(2);
  endfunction

  // Branch targets are forced halfword aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_component_sat_counter16.sv
// sat_counter16
//   16-bit up counter that sticks at 16'hFFFF instead of wrapping.
// Ports:
//   clock   - clock, counts on posedge
//   reset_n - asynchronous active-low reset, clears the count
//   enable  - increment by one this cycle (ignored once saturated)
//   clear   - synchronous clear, takes priority over enable
//   count   - current count value
module sat_counter16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_stage_component.sv
// fetch_stage_component
//   Instruction fetch stage with IF/ID pipeline register. Advances the PC by
//   one halfword per cycle, freezes on a hazard stall, and squashes/redirects
//   on a taken branch. Tracks hold duration (sticky timeout flag) and keeps
//   saturating stall and flush statistics.
// Parameters:
//   RESET_PC - PC loaded at reset
//   NOP_INST - bubble instruction placed into IF/ID
//   MAX_HOLD - consecutive hold cycles that raise hold_timeout (1..255)
// Ports:
//   clock          - clock, all state changes on posedge
//   reset_n        - asynchronous active-low reset
//   stall          - active-low: 0 = hold fetch and IF/ID, 1 = advance
//   flush          - active-high: branch taken, squash and redirect
//   branch_target  - redirect address, used only while flush=1
//   instruction_in - instruction memory data for address pc (same cycle)
//   pc             - registered fetch address
//   if_id_inst     - registered IF/ID instruction
//   if_id_pc       - registered address of if_id_inst
//   if_id_valid    - 1 = real instruction, 0 = bubble
//   hold_timeout   - sticky flag, hold lasted MAX_HOLD cycles
//   stall_count    - saturating count of cycles spent holding
//   flush_count    - saturating count of accepted flushes
module fetch_stage_component
  import fetch_stage_component_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT,
  parameter int unsigned       MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] instruction_in,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              hold_timeout,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
);

  localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

  fetch_state_e state_q, state_d;
  logic         do_fetch, do_hold, do_redirect;
  logic [7:0]   hold_q, hold_d;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_RUN:      state_d = stall ? ST_RUN : ST_HOLD;
        ST_HOLD:     state_d = stall ? ST_RUN : ST_HOLD;
        ST_REDIRECT: state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // Action decode. After a redirect IF/ID holds a bubble, so a stall
  // request has nothing to protect and the fetch proceeds anyway.
  always_comb begin
    do_redirect = flush;
    do_fetch    = 1'b0;
    do_hold     = 1'b0;
    if (!flush) begin
      if (state_q == ST_REDIRECT || stall) begin
        do_fetch = 1'b1;
      end else begin
        do_hold = 1'b1;
      end
    end
  end

  // Hold-length counter: starts at 1 on entering HOLD, saturates at 255
  always_comb begin
    hold_d = hold_q;
    if (do_redirect || do_fetch) begin
      hold_d = '0;
    end else if (do_hold) begin
      if (state_q != ST_HOLD) begin
        hold_d = 8'd1;
      end else if (hold_q != '1) begin
        hold_d = hold_q + 8'd1;
      end
    end
  end

  // Fetch datapath and IF/ID register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      if_id_inst   <= NOP_INST;
      if_id_pc     <= '0;
      if_id_valid  <= 1'b0;
      hold_q       <= '0;
      hold_timeout <= 1'b0;
    end else begin
      hold_q <= hold_d;
      if (do_hold && (hold_d >= MAX_HOLD_L)) begin
        hold_timeout <= 1'b1;
      end
      if (do_redirect) begin
        pc          <= align_pc(branch_target);
        if_id_inst  <= NOP_INST;
        if_id_pc    <= '0;
        if_id_valid <= 1'b0;
      end else if (do_fetch) begin
        pc          <= next_pc(pc);
        if_id_inst  <= instruction_in;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
      end
    end
  end

  sat_counter16 u_stall_count (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (do_hold),
    .clear   (1'b0),
    .count   (stall_count)
  );

  sat_counter16 u_flush_count (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (do_redirect),
    .clear   (1'b0),
    .count   (flush_count)
  );

endmodule
